// File: rtl/alsu_pipe.sv
// alsu_pipe: handshaked, parametrised ALSU with WIDTH-bit signed operands and a 2*WIDTH-bit result.
// One operation is in flight at a time; multiply is iterative and the result is held until the sink takes it.
module alsu_pipe #(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  input  logic                 direction,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 err,
  output logic [LED_W-1:0]     leds
);

  localparam int OW      = 2 * WIDTH;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_serial;
  logic             r_redA;
  logic             r_redB;
  logic             r_bypA;
  logic             r_bypB;
  logic             r_dir;
  logic [2:0]       r_op;

  logic [OW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [OW-1:0]    r_acc;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;

  logic [OW-1:0]    r_out;
  logic             r_err;
  logic [LED_W-1:0] r_leds;

  logic             w_goMul;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [OW-1:0]    w_extA;
  logic [OW-1:0]    w_extB;
  logic [WIDTH-1:0] w_bypSel;
  logic [WIDTH-1:0] w_redSel;
  logic [WIDTH:0]   w_sum;
  logic             w_invalid;
  logic [OW-1:0]    w_execOut;
  logic             w_execErr;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
  assign err       = r_err;
  assign leds      = r_leds;

  // Only a plain, valid multiply takes the iterative path; bypassed or invalid ones resolve in EXEC.
  assign w_goMul = (opcode == 3'd3) & ~bypass_A & ~bypass_B & ~red_op_A & ~red_op_B;
  assign w_magA  = A[WIDTH-1] ? -A : A;
  assign w_magB  = B[WIDTH-1] ? -B : B;

  assign w_extA    = {{(OW-WIDTH){r_a[WIDTH-1]}}, r_a};
  assign w_extB    = {{(OW-WIDTH){r_b[WIDTH-1]}}, r_b};
  assign w_bypSel  = (r_bypA & r_bypB) ? (PRIO_A ? r_a : r_b) : (r_bypA ? r_a : r_b);
  assign w_redSel  = (r_redA & r_redB) ? (PRIO_A ? r_a : r_b) : (r_redA ? r_a : r_b);
  assign w_sum     = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b} + {{WIDTH{1'b0}}, (r_cin & USE_CIN)};
  assign w_invalid = ((r_redA | r_redB) & (r_op[2] | r_op[1])) | (r_op[2:1] == 2'b11);

  always_comb begin
    w_execOut = '0;
    w_execErr = 1'b0;
    if (r_bypA | r_bypB) begin
      w_execOut = {{(OW-WIDTH){w_bypSel[WIDTH-1]}}, w_bypSel};
    end else if (w_invalid) begin
      w_execErr = 1'b1;
    end else begin
      case (r_op)
        3'd0:    w_execOut = (r_redA | r_redB) ? {{(OW-1){1'b0}}, |w_redSel} : (w_extA | w_extB);
        3'd1:    w_execOut = (r_redA | r_redB) ? {{(OW-1){1'b0}}, ^w_redSel} : (w_extA ^ w_extB);
        3'd2:    w_execOut = {{(OW-WIDTH-1){w_sum[WIDTH]}}, w_sum};
        3'd4:    w_execOut = r_dir ? {r_out[OW-2:0], r_serial} : {r_serial, r_out[OW-1:1]};
        3'd5:    w_execOut = r_dir ? {r_out[OW-2:0], r_out[OW-1]} : {r_out[0], r_out[OW-1:1]};
        default: w_execOut = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_goMul ? S_MUL : S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_MUL:   if (r_cnt == CW'(WIDTH)) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply works on magnitudes; one partial product per cycle, then a final cycle applies the sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_serial <= 1'b0;
      r_redA   <= 1'b0;
      r_redB   <= 1'b0;
      r_bypA   <= 1'b0;
      r_bypB   <= 1'b0;
      r_dir    <= 1'b0;
      r_op     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_cin    <= cin;
            r_serial <= serial_in;
            r_redA   <= red_op_A;
            r_redB   <= red_op_B;
            r_bypA   <= bypass_A;
            r_bypB   <= bypass_B;
            r_dir    <= direction;
            r_op     <= opcode;
            r_mcand  <= {{(OW-WIDTH){1'b0}}, w_magA};
            r_mplier <= w_magB;
            r_acc    <= '0;
            r_neg    <= A[WIDTH-1] ^ B[WIDTH-1];
            r_cnt    <= '0;
          end
        end
        S_EXEC: begin
          r_out <= w_execOut;
          r_err <= w_execErr;
        end
        S_MUL: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_out <= r_neg ? -r_acc : r_acc;
            r_err <= 1'b0;
          end else begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_leds <= '0;
    end else if (r_err) begin
      r_leds <= ~r_leds;
    end else begin
      r_leds <= '0;
    end
  end

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe: two instances (priority A / full adder, priority B / half adder)
// share stimulus and are compared against an arithmetic reference model.
module tb_alsu_pipe;

  localparam int WIDTH = 3;
  localparam int OW    = 2 * WIDTH;
  localparam int LED_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inValid = 1'b0;
  logic [WIDTH-1:0] opA = '0;
  logic [WIDTH-1:0] opB = '0;
  logic             cinIn = 1'b0;
  logic             serialIn = 1'b0;
  logic             redOpA = 1'b0;
  logic             redOpB = 1'b0;
  logic             bypassA = 1'b0;
  logic             bypassB = 1'b0;
  logic             dirIn = 1'b0;
  logic [2:0]       opcodeIn = '0;
  logic             outReady = 1'b0;

  logic             inReady1, outValid1, err1;
  logic [OW-1:0]    result1;
  logic [LED_W-1:0] leds1;
  logic             inReady2, outValid2, err2;
  logic [OW-1:0]    result2;
  logic [LED_W-1:0] leds2;

  int assertCount = 0;
  int failCount   = 0;
  int prevOut1    = 0;
  int prevOut2    = 0;

  alsu_pipe #(.WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LED_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1), .A(opA), .B(opB),
    .cin(cinIn), .serial_in(serialIn), .red_op_A(redOpA), .red_op_B(redOpB),
    .bypass_A(bypassA), .bypass_B(bypassB), .direction(dirIn), .opcode(opcodeIn),
    .out_valid(outValid1), .out_ready(outReady), .out(result1), .err(err1), .leds(leds1)
  );

  alsu_pipe #(.WIDTH(WIDTH), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(LED_W)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady2), .A(opA), .B(opB),
    .cin(cinIn), .serial_in(serialIn), .red_op_A(redOpA), .red_op_B(redOpB),
    .bypass_A(bypassA), .bypass_B(bypassB), .direction(dirIn), .opcode(opcodeIn),
    .out_valid(outValid2), .out_ready(outReady), .out(result2), .err(err2), .leds(leds2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on 3-bit signed operands, results wrapped to 6 bits.
  function automatic void refModel(input int a, input int b, input bit cinV, input bit serV,
                                   input bit rA, input bit rB, input bit bA, input bit bB,
                                   input bit dirV, input int op, input int prev,
                                   input bit prioA, input bit fullAdd,
                                   output int res, output bit errV);
    int pick;
    int s;
    errV = 1'b0;
    res  = 0;
    if (bA || bB) begin
      pick = (bA && bB) ? (prioA ? a : b) : (bA ? a : b);
      res  = pick & 63;
    end else if (((rA || rB) && op >= 2) || op >= 6) begin
      res  = 0;
      errV = 1'b1;
    end else begin
      pick = (rA && rB) ? (prioA ? a : b) : (rA ? a : b);
      case (op)
        0: res = (rA || rB) ? (((pick & 7) != 0) ? 1 : 0) : ((a | b) & 63);
        1: res = (rA || rB) ? ($countones(pick & 7) % 2) : ((a ^ b) & 63);
        2: begin
          s = a + b + (fullAdd ? int'(cinV) : 0);
          s = s & 15;
          if (s >= 8) s = s - 16;
          res = s & 63;
        end
        3: res = (a * b) & 63;
        4: res = dirV ? (((prev * 2) + int'(serV)) & 63) : ((int'(serV) * 32) + (prev / 2));
        default: res = dirV ? (((prev * 2) & 63) + (prev / 32)) : (((prev % 2) * 32) + (prev / 2));
      endcase
    end
  endfunction

  task automatic applyStimulus(input string tag, input int a, input int b, input bit cinV, input bit serV,
                               input bit rA, input bit rB, input bit bA, input bit bB,
                               input bit dirV, input int op);
    int  exp1, exp2, lat, expLat;
    bit  expErr1, expErr2;
    refModel(a, b, cinV, serV, rA, rB, bA, bB, dirV, op, prevOut1, 1'b1, 1'b1, exp1, expErr1);
    refModel(a, b, cinV, serV, rA, rB, bA, bB, dirV, op, prevOut2, 1'b0, 1'b0, exp2, expErr2);
    expLat = (op == 3 && !bA && !bB && !rA && !rB) ? WIDTH + 1 : 1;
    checkOutput({tag, ".in_ready_idle"}, 32'(inReady1), 32'd1);
    opA      = 3'(a);
    opB      = 3'(b);
    cinIn    = cinV;
    serialIn = serV;
    redOpA   = rA;
    redOpB   = rB;
    bypassA  = bA;
    bypassB  = bB;
    dirIn    = dirV;
    opcodeIn = 3'(op);
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid1 && lat < 20) begin
      checkOutput({tag, ".in_ready_busy"}, 32'(inReady1), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".out1"}, 32'(result1), 32'(exp1));
    checkOutput({tag, ".err1"}, 32'(err1), 32'(expErr1));
    checkOutput({tag, ".out_valid2"}, 32'(outValid2), 32'd1);
    checkOutput({tag, ".out2"}, 32'(result2), 32'(exp2));
    checkOutput({tag, ".err2"}, 32'(err2), 32'(expErr2));
    prevOut1 = exp1;
    prevOut2 = exp2;
  endtask

  task automatic releaseResult(input string tag);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, ".out_valid_drop"}, 32'(outValid1), 32'd0);
    checkOutput({tag, ".in_ready_back"}, 32'(inReady1), 32'd1);
    checkOutput({tag, ".out_held"}, 32'(result1), 32'(prevOut1));
  endtask

  initial begin
    int a, b, op;
    bit expLedsOn;

    $display("[TB] alsu_pipe bench starting");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.out", 32'(result1), 32'd0);
    checkOutput("reset.out_valid", 32'(outValid1), 32'd0);
    checkOutput("reset.err", 32'(err1), 32'd0);
    checkOutput("reset.leds", 32'(leds1), 32'd0);
    checkOutput("reset.in_ready", 32'(inReady1), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("add_3_3_c1", 3, 3, 1, 0, 0, 0, 0, 0, 0, 2);
    releaseResult("add_3_3_c1");
    applyStimulus("mul_m4_m4", -4, -4, 0, 0, 0, 0, 0, 0, 0, 3);
    releaseResult("mul_m4_m4");
    applyStimulus("mul_m4_3", -4, 3, 0, 0, 0, 0, 0, 0, 0, 3);
    releaseResult("mul_m4_3");

    applyStimulus("bp_add", -2, 1, 0, 0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 10; i++) begin
      inValid  = 1'($urandom_range(0, 1));
      opA      = 3'($urandom_range(0, 7));
      opcodeIn = 3'($urandom_range(0, 5));
      @(posedge clk);
      #1;
      checkOutput("bp.out", 32'(result1), 32'(prevOut1));
      checkOutput("bp.out_valid", 32'(outValid1), 32'd1);
      checkOutput("bp.in_ready", 32'(inReady1), 32'd0);
    end
    inValid = 1'b0;
    releaseResult("bp_add");

    applyStimulus("invalid_redA_add", 1, 2, 0, 0, 1, 0, 0, 0, 0, 2);
    checkOutput("inv.leds_entry", 32'(leds1), 32'd0);
    expLedsOn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      expLedsOn = ~expLedsOn;
      checkOutput("inv.leds1", 32'(leds1), expLedsOn ? 32'h0000FFFF : 32'd0);
      checkOutput("inv.leds2", 32'(leds2), expLedsOn ? 32'h0000FFFF : 32'd0);
    end
    releaseResult("invalid_redA_add");
    applyStimulus("recover_add", 1, 1, 0, 0, 0, 0, 0, 0, 0, 2);
    releaseResult("recover_add");
    checkOutput("recover.leds", 32'(leds1), 32'd0);
    checkOutput("recover.err", 32'(err1), 32'd0);

    applyStimulus("seed7_a", 3, 3, 1, 0, 0, 0, 0, 0, 0, 2);
    releaseResult("seed7_a");
    applyStimulus("shift_left", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    releaseResult("shift_left");
    applyStimulus("seed7_b", 3, 3, 1, 0, 0, 0, 0, 0, 0, 2);
    releaseResult("seed7_b");
    applyStimulus("rotate_right", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    releaseResult("rotate_right");
    applyStimulus("shift_right_s1", 0, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    releaseResult("shift_right_s1");
    applyStimulus("bypass_both", -3, 2, 0, 0, 0, 0, 1, 1, 0, 7);
    releaseResult("bypass_both");
    applyStimulus("red_or_both", 0, -1, 0, 0, 1, 1, 0, 0, 0, 0);
    releaseResult("red_or_both");
    applyStimulus("red_xor_B", 2, 3, 0, 0, 0, 1, 0, 0, 0, 1);
    releaseResult("red_xor_B");
    applyStimulus("opcode6", 1, 1, 0, 0, 0, 0, 0, 0, 0, 6);
    releaseResult("opcode6");

    for (int i = 0; i < 40; i++) begin
      a  = int'($urandom_range(0, 7)) - 4;
      b  = int'($urandom_range(0, 7)) - 4;
      op = int'($urandom_range(0, 7));
      applyStimulus("random", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)), op);
      releaseResult("random");
    end

    opA      = 3'(-4);
    opB      = 3'(3);
    opcodeIn = 3'd3;
    redOpA   = 1'b0;
    redOpB   = 1'b0;
    bypassA  = 1'b0;
    bypassB  = 1'b0;
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst.out", 32'(result1), 32'd0);
    checkOutput("midrst.out_valid", 32'(outValid1), 32'd0);
    checkOutput("midrst.in_ready", 32'(inReady1), 32'd1);
    checkOutput("midrst.err", 32'(err1), 32'd0);
    checkOutput("midrst.leds", 32'(leds1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prevOut1 = 0;
    prevOut2 = 0;
    applyStimulus("post_rst_add", 2, -1, 1, 0, 0, 0, 0, 0, 0, 2);
    releaseResult("post_rst_add");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
